hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_sb_entry.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 89 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard scoreboard.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package hazard_pkg;

  localparam int unsigned NREG_DEF     = 32;
  localparam int unsigned AW_DEF       = $clog2(NREG_DEF);
  localparam int unsigned LOAD_LAT_DEF = 1;

  typedef logic [AW_DEF-1:0] reg_addr_t;

  // x0 is hardwired zero: it never becomes busy and never causes a stall.
  localparam reg_addr_t X0 = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    sat_inc32 = (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: busy flag plus a countdown of the remaining load
// bubbles. A fresh issue always reloads the countdown, even mid-count.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CW       = $clog2(LOAD_LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic dec_en,
  output logic busy
);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (issue) begin
      busy_d = 1'b1;
      cnt_d  = CW'(LOAD_LAT);
    end else if (dec_en && busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: tracks pending load destinations and raises
// stall / flush controls. Define HAZARD_STATS_EN to add stall/flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned AW       = $clog2(NREG),
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CW       = $clog2(LOAD_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_memread,
  input  logic            ex_branch_taken,
  input  logic            mem_wait,
  output logic            stall,
  output logic            if_flush,
  output logic            id_flush,
  output logic [NREG-1:0] busy_vec
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_events
`endif
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] issue_vec;
  logic            dep_rs1;
  logic            dep_rs2;
  logic            issue;

  assign dep_rs1 = id_rs1_used && (id_rs1 != '0) && busy[id_rs1];
  assign dep_rs2 = id_rs2_used && (id_rs2 != '0) && busy[id_rs2];

  // A taken branch squashes ID, so the flush masks both the stall and the issue.
  assign stall    = id_valid && !ex_branch_taken && (dep_rs1 || dep_rs2);
  assign if_flush = ex_branch_taken;
  assign id_flush = ex_branch_taken || stall;

  assign issue = id_valid && id_memread && (id_rd != '0) && !stall && !ex_branch_taken;

  for (genvar r = 0; r < NREG; r++) begin : g_entry
    assign issue_vec[r] = (r != int'(X0)) && issue && (id_rd == AW'(r));

    hazard_sb_entry #(
      .LOAD_LAT (LOAD_LAT),
      .CW       (CW)
    ) u_entry (
      .clk    (clk),
      .rst    (rst),
      .issue  (issue_vec[r]),
      .dec_en (!mem_wait),
      .busy   (busy[r])
    );
  end

  assign busy_vec = busy;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = sat_inc32(stall_cycles_q, stall);
    flush_events_d = sat_inc32(flush_events_q, ex_branch_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule
